// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add controller for R = a*P over an external point unit.
// Define ECC_CONST_TIME_EN to issue a (discarded) add for every zero scalar bit once R is finite.
module ecc_scalar_mult_ctrl #(
    parameter int unsigned MAX_BITS = 256,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_sel,
    input  logic [1:0]          i_mode,
    input  logic [MAX_BITS-1:0] i_Px,
    input  logic [MAX_BITS-1:0] i_Py,
    input  logic [MAX_BITS-1:0] i_a,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_sel,
    output logic [MAX_BITS-1:0] o_Rx,
    output logic [MAX_BITS-1:0] o_Ry,
    output logic                o_R_inf,
    output logic                pu_req,
    output logic                pu_op,
    output logic [MAX_BITS-1:0] pu_ax,
    output logic [MAX_BITS-1:0] pu_ay,
    output logic [MAX_BITS-1:0] pu_bx,
    output logic [MAX_BITS-1:0] pu_by,
    input  logic                pu_ack,
    input  logic [MAX_BITS-1:0] pu_rx,
    input  logic [MAX_BITS-1:0] pu_ry,
    input  logic                pu_rinf
);

    typedef enum logic [2:0] {IDLE, INIT, DBL, ADD, DONE} state_t;

    state_t              state;
    logic [MAX_BITS-1:0] p_x, p_y, a_q, r_x, r_y;
    logic                r_inf, sel_q;
    logic [CNT_W-1:0]    idx;

    logic                bit_set, add_need, add_leave;
    logic [MAX_BITS-1:0] n_x, n_y;
    logic                n_inf;

    function automatic logic [CNT_W-1:0] top_idx(input logic [1:0] mode);
        case (mode)
            2'b00:   top_idx = CNT_W'(31);
            2'b01:   top_idx = CNT_W'(63);
            2'b10:   top_idx = CNT_W'(127);
            default: top_idx = CNT_W'(255);
        endcase
    endfunction

    assign pu_ax = r_x;
    assign pu_ay = r_y;
    assign pu_bx = p_x;
    assign pu_by = p_y;

    // Next accumulator value when the current ADD step completes.
    always_comb begin
        bit_set = a_q[idx];
`ifdef ECC_CONST_TIME_EN
        add_need = !r_inf;
`else
        add_need = !r_inf && bit_set;
`endif
        add_leave = (state == ADD) && (pu_req ? pu_ack : !add_need);
        n_x   = r_x;
        n_y   = r_y;
        n_inf = r_inf;
        if (pu_req && pu_ack && bit_set) begin
            n_x   = pu_rx;
            n_y   = pu_ry;
            n_inf = pu_rinf;
        end else if (!pu_req && bit_set && r_inf) begin
            n_x   = p_x;
            n_y   = p_y;
            n_inf = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            p_x     <= '0;
            p_y     <= '0;
            a_q     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_inf   <= 1'b0;
            sel_q   <= 1'b0;
            idx     <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sel   <= 1'b0;
            o_Rx    <= '0;
            o_Ry    <= '0;
            o_R_inf <= 1'b0;
            pu_req  <= 1'b0;
            pu_op   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        p_x    <= i_Px;
                        p_y    <= i_Py;
                        a_q    <= i_a;
                        sel_q  <= i_sel;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_inf  <= 1'b1;
                        idx    <= top_idx(i_mode);
                        o_busy <= 1'b1;
                        state  <= INIT;
                    end
                end
                INIT: state <= DBL;
                DBL: begin
                    if (r_inf) begin
                        state <= ADD;
                    end else if (!pu_req) begin
                        pu_req <= 1'b1;
                        pu_op  <= 1'b0;
                    end else if (pu_ack) begin
                        r_x    <= pu_rx;
                        r_y    <= pu_ry;
                        r_inf  <= pu_rinf;
                        pu_req <= 1'b0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (pu_req) begin
                        if (pu_ack) pu_req <= 1'b0;
                    end else if (add_need) begin
                        pu_req <= 1'b1;
                        pu_op  <= 1'b1;
                    end
                    if (add_leave) begin
                        r_x   <= n_x;
                        r_y   <= n_y;
                        r_inf <= n_inf;
                        if (idx == '0) begin
                            o_done  <= 1'b1;
                            o_sel   <= sel_q;
                            o_R_inf <= n_inf;
                            o_Rx    <= n_inf ? '0 : n_x;
                            o_Ry    <= n_inf ? '0 : n_y;
                            state   <= DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= DBL;
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
